// File: rtl/vc_out_mux_buf_pkg.sv
// Shared router definitions: default widths, port count, port indices, flit layout.
package vc_out_mux_buf_pkg;

    localparam int DATAW_DFLT = 8;
    localparam int VCHW_DFLT  = 1;
    localparam int NPORT_DFLT = 5;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    typedef struct packed {
        logic [DATAW_DFLT-1:0] data;
        logic [VCHW_DFLT-1:0]  vch;
    } flit_t;

endpackage

// File: rtl/vc_out_mux_buf_sync_fifo.sv
// Generic show-ahead synchronous FIFO. The caller guarantees no push when full
// and no pop when empty. While empty, rdata keeps the most recently popped word.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // The slot just behind rd_ptr is only rewritten after a push makes the FIFO
    // non-empty, so it still holds the last popped word while empty.
    assign rdata = (count == '0) ? mem[rd_ptr - AW'(1)] : mem[rd_ptr];

    // Storage, pointers and occupancy; reset discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vc_out_mux_buf.sv
// Registered router output-port mux: one-hot grant selects an input stream,
// accepted flits are queued and presented to the output link with valid/ready.
module vc_out_mux_buf
    import vc_out_mux_buf_pkg::*;
#(
    parameter int NPORT = NPORT_DFLT,
    parameter int DATAW = DATAW_DFLT,
    parameter int VCHW  = VCHW_DFLT,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORT*DATAW-1:0]   idata,
    input  logic [NPORT-1:0]         ivalid,
    input  logic [NPORT*VCHW-1:0]    ivch,
    input  logic [NPORT-1:0]         sel,
    output logic [NPORT-1:0]         iready,
    output logic [DATAW-1:0]         odata,
    output logic                     ovalid,
    output logic [VCHW-1:0]          ovch,
    input  logic                     oready,
    output logic                     sel_err,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int FW   = DATAW + VCHW;

    logic [NPORT-1:0] sel_m1;
    logic             multihot;
    logic             onehot;
    logic             space;
    logic             push;
    logic             pop;
    logic [DATAW-1:0] mux_data;
    logic [VCHW-1:0]  mux_vch;
    logic             mux_valid;
    logic [FW-1:0]    rdata;

    // sel & (sel-1) clears the lowest set bit; anything left means multi-hot.
    assign sel_m1   = sel - {{(NPORT-1){1'b0}}, 1'b1};
    assign multihot = |(sel & sel_m1);
    assign onehot   = (|sel) & ~multihot;
    assign space    = (count < CNTW'(DEPTH));

    // Ready depends only on the grant and occupancy, never on oready.
    assign iready = (onehot && space) ? sel : '0;

    // AND-OR select of the granted port; only meaningful when onehot is set.
    always_comb begin
        mux_data  = '0;
        mux_vch   = '0;
        mux_valid = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (sel[i]) begin
                mux_data  = mux_data  | idata[i*DATAW +: DATAW];
                mux_vch   = mux_vch   | ivch[i*VCHW +: VCHW];
                mux_valid = mux_valid | ivalid[i];
            end
        end
    end

    assign push   = onehot & mux_valid & space;
    assign ovalid = (count != '0);
    assign pop    = ovalid & oready;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({mux_data, mux_vch}),
        .rdata (rdata),
        .count (count)
    );

    assign odata = rdata[FW-1:VCHW];
    assign ovch  = rdata[VCHW-1:0];

    // One-cycle error pulse for every cycle the grant was multi-hot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sel_err <= 1'b0;
        else        sel_err <= multihot;
    end

endmodule
